// File: rtl/fib_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fib_stream_gen
//  Description : Fibonacci term generator that streams bursts of terms over a
//                valid/ready interface. The (a, b) pair persists across bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_stream_gen #(
  parameter int                 WIDTH    = 8,
  parameter int                 LEN_W    = 8,
  parameter logic [WIDTH-1:0]   SEED_A   = '0,
  parameter logic [WIDTH-1:0]   SEED_B   = WIDTH'(1),
  parameter int                 SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_a,
  input  logic [WIDTH-1:0]  seed_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_two = LEN_W'(2);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [LEN_W-1:0]   r_rem;
  logic               r_last;
  logic               r_done;
  logic               r_ovf;

  logic [WIDTH:0]     w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_next;
  logic               w_xfer;

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry = w_sum[WIDTH];
  assign w_xfer  = (r_state == ST_RUN) && out_ready;

  if (SATURATE != 0) begin : g_sat
    assign w_next = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
  end else begin : g_wrap
    assign w_next = w_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= SEED_A;
      r_b     <= SEED_B;
      r_rem   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (seed_load) begin
            r_a <= seed_a;
            r_b <= seed_b;
          end
          if (start) begin
            if (len != '0) begin
              r_state <= ST_RUN;
              r_rem   <= len;
              r_last  <= (len == c_one);
              r_ovf   <= 1'b0;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_a   <= r_b;
            r_b   <= w_next;
            r_rem <= r_rem - c_one;
            if (w_carry) r_ovf <= 1'b1;
            // Final term accepted: drop back to IDLE and flag completion.
            if (r_rem == c_one) begin
              r_state <= ST_IDLE;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_last  <= (r_rem == c_two);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign out_data  = r_a;
  assign out_last  = r_last;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fib_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_stream_gen
//  Description : Self-checking bench for fib_stream_gen, wrap and saturate
//                builds driven side by side against an integer term model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_stream_gen;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [7:0]   len;
  logic         seed_load;
  logic [W-1:0] seed_a;
  logic [W-1:0] seed_b;
  logic         out_ready;

  logic         v  [2];
  logic [W-1:0] d  [2];
  logic         l  [2];
  logic         bz [2];
  logic         dn [2];
  logic         of [2];

  int tests = 0;
  int fails = 0;

  fib_stream_gen #(.WIDTH(W), .LEN_W(8), .SEED_A(8'd0), .SEED_B(8'd1), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed_load(seed_load),
    .seed_a(seed_a), .seed_b(seed_b), .out_valid(v[0]), .out_ready(out_ready),
    .out_data(d[0]), .out_last(l[0]), .busy(bz[0]), .done(dn[0]), .ovf(of[0])
  );

  fib_stream_gen #(.WIDTH(W), .LEN_W(8), .SEED_A(8'd0), .SEED_B(8'd1), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed_load(seed_load),
    .seed_a(seed_a), .seed_b(seed_b), .out_valid(v[1]), .out_ready(out_ready),
    .out_data(d[1]), .out_last(l[1]), .busy(bz[1]), .done(dn[1]), .ovf(of[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Term-level model: plain integers for the pair, terms left in the burst,
  // the sticky overflow and a pending done pulse.
  int m_a [2];
  int m_b [2];
  int m_left [2];
  int m_ovf [2];
  int m_done [2];
  int dcnt [2];
  int gq0[$], gq1[$], mq0[$], mq1[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int s);
    int sum;
    int nxt;
    int dnext;
    if (rst) begin
      m_a[s] = 0; m_b[s] = 1; m_left[s] = 0; m_ovf[s] = 0; m_done[s] = 0;
      chk($sformatf("rst_valid[%0d]", s), int'(v[s]), 0);
      chk($sformatf("rst_data[%0d]", s), int'(d[s]), 0);
      chk($sformatf("rst_done[%0d]", s), int'(dn[s]), 0);
      chk($sformatf("rst_ovf[%0d]", s), int'(of[s]), 0);
      return;
    end
    chk($sformatf("valid[%0d]", s), int'(v[s]), (m_left[s] > 0) ? 1 : 0);
    chk($sformatf("busy[%0d]", s), int'(bz[s]), (m_left[s] > 0) ? 1 : 0);
    chk($sformatf("last[%0d]", s), int'(l[s]), (m_left[s] == 1) ? 1 : 0);
    chk($sformatf("data[%0d]", s), int'(d[s]), m_a[s]);
    chk($sformatf("done[%0d]", s), int'(dn[s]), m_done[s]);
    chk($sformatf("ovf[%0d]", s), int'(of[s]), m_ovf[s]);
    if (dn[s]) dcnt[s]++;
    dnext = 0;
    if (m_left[s] > 0) begin
      if (out_ready) begin
        if (s == 0) begin gq0.push_back(int'(d[0])); mq0.push_back(m_a[0]); end
        else        begin gq1.push_back(int'(d[1])); mq1.push_back(m_a[1]); end
        sum = m_a[s] + m_b[s];
        if (sum > MAX) m_ovf[s] = 1;
        if (s == 1 && sum > MAX) nxt = MAX;
        else                     nxt = sum % (MAX + 1);
        m_a[s] = m_b[s];
        m_b[s] = nxt;
        m_left[s]--;
        if (m_left[s] == 0) dnext = 1;
      end
    end else begin
      if (seed_load) begin
        m_a[s] = int'(seed_a);
        m_b[s] = int'(seed_b);
      end
      if (start) begin
        if (len != 0) begin
          m_left[s] = int'(len);
          m_ovf[s]  = 0;
        end else begin
          dnext = 1;
        end
      end
    end
    m_done[s] = dnext;
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) model_step(s);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int n, input logic sl, input int sa, input int sb);
    start = 1'b1; len = 8'(n); seed_load = sl; seed_a = W'(sa); seed_b = W'(sb);
    step(1);
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (bz[0] && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_idle_timeout", int'(bz[0]), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic clear_q();
    gq0.delete(); gq1.delete(); mq0.delete(); mq1.delete();
    dcnt[0] = 0; dcnt[1] = 0;
  endtask

  task automatic check_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", nm, i), got[i], exp[i]);
  endtask

  int e_q[$];
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; seed_load = 1'b0;
    seed_a = '0; seed_b = '0; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset_data", int'(d[0]), 0);
    chk("reset_ovf", int'(of[0]), 0);

    // Scenario 1: thirteen terms, last one overflows on the pair update.
    clear_q();
    out_ready = 1'b1;
    do_start(13, 1'b0, 0, 0);
    wait_idle(50);
    step(2);
    e_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
    check_seq("s1_dut_wrap", gq0, e_q);
    check_seq("s1_model_wrap", mq0, e_q);
    check_seq("s1_dut_sat", gq1, e_q);
    chk("s1_done_count", dcnt[0], 1);
    chk("s1_ovf_wrap", int'(of[0]), 1);
    chk("s1_ovf_sat", int'(of[1]), 1);

    // Scenarios 2/3: continuation, wrap vs saturate.
    clear_q();
    do_start(3, 1'b0, 0, 0);
    chk("s2_ovf_cleared", int'(of[0]), 0);
    wait_idle(50);
    step(2);
    e_q = '{233, 121, 98};
    check_seq("s2_dut_wrap", gq0, e_q);
    check_seq("s2_model_wrap", mq0, e_q);
    e_q = '{233, 255, 255};
    check_seq("s3_dut_sat", gq1, e_q);
    check_seq("s3_model_sat", mq1, e_q);
    chk("s3_ovf_sat", int'(of[1]), 1);

    // Scenario 4: backpressure.
    apply_reset();
    clear_q();
    do_start(4, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      step(1);
    end
    out_ready = 1'b1;
    step(3);
    e_q = '{0, 1, 1, 2};
    check_seq("s4_dut", gq0, e_q);
    chk("s4_done_count", dcnt[0], 1);

    // Scenario 5: seed load with start, then commands ignored while running.
    apply_reset();
    clear_q();
    do_start(3, 1'b1, 10, 20);
    wait_idle(50);
    step(2);
    e_q = '{10, 20, 30};
    check_seq("s5_seed", gq0, e_q);
    clear_q();
    do_start(3, 1'b0, 0, 0);
    start = 1'b1; len = 8'd5; seed_load = 1'b1; seed_a = 8'd99; seed_b = 8'd99;
    step(1);
    start = 1'b0; seed_load = 1'b0;
    wait_idle(50);
    step(3);
    e_q = '{50, 80, 130};
    check_seq("s5_ignore", gq0, e_q);

    // Scenario 6: zero-length start, reset mid-burst, maximum length.
    clear_q();
    do_start(0, 1'b0, 0, 0);
    step(3);
    chk("s6_len0_done", dcnt[0], 1);
    chk("s6_len0_terms", gq0.size(), 0);
    do_start(10, 1'b0, 0, 0);
    step(3);
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", int'(v[0]), 0);
    chk("s6_rst_busy", int'(bz[0]), 0);
    chk("s6_rst_last", int'(l[0]), 0);
    chk("s6_rst_data", int'(d[0]), 0);
    step(1);
    rst = 1'b0;
    step(1);
    clear_q();
    do_start(2, 1'b0, 0, 0);
    wait_idle(50);
    step(2);
    e_q = '{0, 1};
    check_seq("s6_after_rst", gq0, e_q);
    chk("s6_no_stale_done", dcnt[0], 1);
    clear_q();
    do_start(255, 1'b0, 0, 0);
    wait_idle(400);
    step(2);
    chk("s6_maxlen_terms", gq0.size(), 255);
    chk("s6_maxlen_done", dcnt[0], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
